// File: rtl/mult_sched.sv
// Two-client round-robin scheduler that time-shares one multiplier and its product memory.
// Optional read-phase watchdog is built when MULT_SCHED_TIMEOUT_EN is defined.
module mult_sched #(
  parameter int DEPTH          = 64,
  parameter int OP_W           = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_c0,
  input  logic              REQ_c1,
  output logic              GNT_c0,
  output logic              GNT_c1,
  input  logic              EN_c0,
  input  logic              EN_c1,
  input  logic [OP_W-1:0]   in0_c0,
  input  logic [OP_W-1:0]   in1_c0,
  input  logic [OP_W-1:0]   in0_c1,
  input  logic [OP_W-1:0]   in1_c1,
  output logic              RDY_c0,
  output logic              RDY_c1,
  output logic              RES_VALID_c0,
  output logic              RES_VALID_c1,
  output logic              RES_LAST_c0,
  output logic              RES_LAST_c1,
  output logic [DATA_W-1:0] RES_DATA_c0,
  output logic [DATA_W-1:0] RES_DATA_c1,
  output logic              EN_mult,
  output logic [OP_W-1:0]   mult_input0,
  output logic [OP_W-1:0]   mult_input1,
  input  logic              RDY_mult,
  output logic              EN_blockRead,
  input  logic              VALID_memVal,
  input  logic [DATA_W-1:0] memVal_data,
  output logic              ERR_timeout
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FILL     = 2'd1;
  localparam logic [1:0] S_READ_REQ = 2'd2;
  localparam logic [1:0] S_READ     = 2'd3;

  if (DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mult_sched: DEPTH and TIMEOUT_CYCLES must be positive");
  end

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;   // 0 = c0, 1 = c1
  logic          ptr_q, ptr_d;       // client favoured on a simultaneous request
  logic          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          eb_q, eb_d;

  logic in_fill, in_read, win_en, beat_in, beat_out, last_out;

  assign in_fill  = (state_q == S_FILL);
  assign in_read  = (state_q == S_READ_REQ) || (state_q == S_READ);
  assign win_en   = owner_q ? EN_c1 : EN_c0;
  assign beat_in  = in_fill && win_en && RDY_mult;
  assign beat_out = in_read && VALID_memVal;
  assign last_out = beat_out && (cnt_q == LAST_BEAT);

  assign GNT_c0       = gnt_q && !owner_q;
  assign GNT_c1       = gnt_q &&  owner_q;
  assign RDY_c0       = in_fill && !owner_q && RDY_mult;
  assign RDY_c1       = in_fill &&  owner_q && RDY_mult;
  assign EN_mult      = in_fill && win_en;
  assign mult_input0  = in_fill ? (owner_q ? in0_c1 : in0_c0) : '0;
  assign mult_input1  = in_fill ? (owner_q ? in1_c1 : in1_c0) : '0;
  assign EN_blockRead = eb_q;

  // Readback is a zero-latency pass-through, steered only to the owner
  assign RES_VALID_c0 = beat_out && !owner_q;
  assign RES_VALID_c1 = beat_out &&  owner_q;
  assign RES_LAST_c0  = last_out && !owner_q;
  assign RES_LAST_c1  = last_out &&  owner_q;
  assign RES_DATA_c0  = (beat_out && !owner_q) ? memVal_data : '0;
  assign RES_DATA_c1  = (beat_out &&  owner_q) ? memVal_data : '0;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  assign ERR_timeout = err_q;
`else
  assign ERR_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    eb_d    = eb_q;
    case (state_q)
      S_IDLE: begin
        if ((REQ_c0 || REQ_c1) && RDY_mult) begin
          owner_d = (REQ_c0 && REQ_c1) ? ptr_q : REQ_c1;
          gnt_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (beat_in) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            eb_d    = 1'b1;
            state_d = S_READ_REQ;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        // READ_REQ and READ share the beat logic; the first valid beat is beat 0
        if (beat_out) begin
          eb_d = 1'b0;
          if (last_out) begin
            cnt_d   = '0;
            gnt_d   = 1'b0;
            ptr_d   = ~owner_q;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_READ;
          end
        end
      end
    endcase

`ifdef MULT_SCHED_TIMEOUT_EN
    err_d = 1'b0;
    wd_d  = '0;
    if (in_read && !VALID_memVal) begin
      if (wd_q == WD_LAST) begin
        err_d   = 1'b1;
        eb_d    = 1'b0;
        gnt_d   = 1'b0;
        cnt_d   = '0;
        ptr_d   = ~owner_q;
        state_d = S_IDLE;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      eb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      eb_q    <= eb_d;
    end
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Two-client round-robin scheduler that time-shares one multiplier block and its 64-entry product memory.
- Each granted client owns the multiplier for one complete transaction: a fill of DEPTH operand pairs, then a block readback of DEPTH products.
- Readback data is routed only to the owning client.
- Sits between client logic and the multiplier's EN_mult/RDY_mult/EN_blockRead/VALID_memVal interface.

Parameters:
- DEPTH, 64, operand pairs per transaction; equals the product memory depth.
- OP_W, 16, operand width.
- DATA_W, 32, product/readback width.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with MULT_SCHED_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ_c0, REQ_c1  in  1  client transaction request.
- GNT_c0, GNT_c1  out  1  client owns the multiplier.
- EN_c0, EN_c1  in  1  client operand valid.
- in0_c0, in1_c0, in0_c1, in1_c1  in  OP_W  client operands.
- RDY_c0, RDY_c1  out  1  operand accepted this cycle when EN is also high.
- RES_VALID_c0, RES_VALID_c1  out  1  readback beat valid.
- RES_LAST_c0, RES_LAST_c1  out  1  final readback beat.
- RES_DATA_c0, RES_DATA_c1  out  DATA_W  readback data.
- EN_mult  out  1  to multiplier.
- mult_input0, mult_input1  out  OP_W  to multiplier.
- RDY_mult  in  1  multiplier ready for operands.
- EN_blockRead  out  1  to multiplier.
- VALID_memVal  in  1  readback data valid.
- memVal_data  in  DATA_W  readback data.
- ERR_timeout  out  1  watchdog abort pulse.

Behaviour:
- Reset (RST sampled high at posedge):
  - state=IDLE; priority pointer=c0.
  - All counters 0.
  - All outputs 0: GNT, RDY, RES_*, EN_mult, mult_input*, EN_blockRead, ERR_timeout.
  - Reset mid-transaction aborts immediately. There is no drain and the multiplier is not notified.
- IDLE:
  - If any REQ is high and RDY_mult=1, grant the winner. Go to FILL next cycle with GNT_winner=1.
  - Single requester wins.
  - Both requesting: the client named by the pointer wins.
- FILL:
  - EN_mult = EN_winner; mult_input0/1 = winner's in0/in1 (combinational mux).
  - RDY_winner = RDY_mult. RDY of the loser is 0.
  - Accepted beat = EN_winner && RDY_mult; beat counter increments.
  - On the DEPTH-th accepted beat, go to READ_REQ next cycle.
  - EN_mult is never asserted after DEPTH beats.
- READ_REQ:
  - EN_blockRead=1 (registered) until VALID_memVal is sampled high.
  - The first VALID_memVal cycle is counted as beat 0 of READ and is forwarded.
- READ:
  - RES_VALID_winner = VALID_memVal; RES_DATA_winner = memVal_data (combinational pass-through, zero latency).
  - Loser's RES_* held 0.
  - Count beats.
  - On the DEPTH-th beat: RES_LAST_winner=1, then go to IDLE next cycle. GNT drops and the pointer moves to the other client.
- REQ deassertion after grant is ignored; the transaction always runs to completion.
- Gaps in VALID_memVal or RDY_mult stall the counters; no beats are lost or duplicated.
- Loser's REQ stays pending and is granted in the first IDLE cycle with RDY_mult=1. Back-to-back alternation therefore has exactly one IDLE cycle between transactions.
- Counters are $clog2(DEPTH)+1 bits wide and never wrap within a transaction.
- Without the macro, ERR_timeout is tied 0.

Optional Feature:
- MULT_SCHED_TIMEOUT_EN defined:
  - A watchdog counts consecutive cycles in READ_REQ/READ with VALID_memVal=0 and resets on any valid beat.
  - On reaching TIMEOUT_CYCLES:
    - one-cycle ERR_timeout pulse;
    - EN_blockRead deasserted;
    - GNT dropped;
    - go to IDLE; the pointer advances as on normal completion.
- Not defined: no watchdog logic; the scheduler waits indefinitely; ERR_timeout constant 0.

Test Plan:
- Single-client transaction:
  - Stimulus: REQ_c0 only; 64 pairs (i, 2), i=0..63.
  - Response: GNT_c0 one cycle after REQ; exactly 64 EN_mult beats; EN_blockRead asserted; 64 RES_VALID_c0 beats with data i*2; RES_LAST_c0 on beat 63; GNT_c0 low next cycle.
- Simultaneous requests after reset:
  - Stimulus: REQ_c0 and REQ_c1 both high.
  - Response: c0 served first, then c1 with one IDLE cycle between. With both held, the order is c0,c1,c0,c1. No RES_* pulses to the non-owner.
- Backpressure:
  - Stimulus: RDY_mult toggled 1/0 during FILL; VALID_memVal gaps of 3 cycles during READ.
  - Response: still exactly 64 accepted beats and 64 results, in order with correct values.
- Reset mid-operation:
  - Stimulus: RST asserted at FILL beat 20, then released.
  - Response: all outputs 0 the cycle after the RST edge; the next grant goes to c0 even if c1 was granted before reset.
- REQ drop:
  - Stimulus: REQ_c1 deasserted during READ.
  - Response: the transaction completes with 64 beats to c1.
- Timeout (macro on, TIMEOUT_CYCLES=16):
  - Stimulus: VALID_memVal held 0.
  - Response: ERR_timeout pulses at cycle 16 of READ_REQ; GNT low; next requester granted.
